// File: rtl/comb1_pkg.sv
// -----------------------------------------------------------------------------
// comb1_pkg
// Shared constants for the comb1 lamp/alarm decision block.
//   TT_DEFAULT           default truth table, gives L = (D & X) | A
//   IDX_D / IDX_X / IDX_A bit positions of each input in the table index
//   IDX_W                width of the table index
//   SYNC_STAGES_DEFAULT  default synchronizer depth (legal range 1..4)
//   CNT_W_DEFAULT        default activation counter width
// Helper functions build the table index and perform the table lookup.
// -----------------------------------------------------------------------------
package comb1_pkg;

    localparam logic [7:0]  TT_DEFAULT          = 8'hEA;

    localparam int unsigned IDX_D               = 32'd2;
    localparam int unsigned IDX_X               = 32'd1;
    localparam int unsigned IDX_A               = 32'd0;
    localparam int unsigned IDX_W               = 32'd3;

    localparam int unsigned SYNC_STAGES_DEFAULT = 32'd2;
    localparam int unsigned CNT_W_DEFAULT       = 32'd8;

    // Place the three level inputs at their fixed index positions.
    function automatic logic [IDX_W-1:0] pack_idx(
        input logic d,
        input logic x,
        input logic a
    );
        logic [IDX_W-1:0] idx;
        idx        = 3'b000;
        idx[IDX_D] = d;
        idx[IDX_X] = x;
        idx[IDX_A] = a;
        return idx;
    endfunction

    // Select one bit of the 8-entry truth table.
    function automatic logic tt_lookup(
        input logic [7:0]       tt,
        input logic [IDX_W-1:0] idx
    );
        return tt[idx];
    endfunction

endpackage

// File: rtl/comb1_sync.sv
// -----------------------------------------------------------------------------
// comb1_sync
// N-stage, W-bit flop synchronizer with synchronous active-high reset.
// All bits share one chain, so a bus that changes together emerges together
// (bits with skew near an edge may still arrive one cycle apart).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears every stage
//   d    asynchronous input bus (W bits)
//   q    synchronized output bus, N clk edges behind d
// -----------------------------------------------------------------------------
module comb1_sync #(
    parameter int unsigned N = 32'd2,
    parameter int unsigned W = 32'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stages are packed LSB-first: stage 0 occupies [W-1:0], the last stage
    // occupies the top W bits.
    logic [N*W-1:0] chain_r;

    if (N == 32'd1) begin : g_single
        // Single-stage capture of the asynchronous bus.
        always_ff @(posedge clk) begin
            if (rst) begin
                chain_r <= '0;
            end else begin
                chain_r <= d;
            end
        end
    end else begin : g_multi
        // Shift the bus one stage deeper each clock.
        always_ff @(posedge clk) begin
            if (rst) begin
                chain_r <= '0;
            end else begin
                chain_r <= {chain_r[(N-1)*W-1:0], d};
            end
        end
    end

    assign q = chain_r[N*W-1 -: W];

endmodule

// File: rtl/comb1_core.sv
// -----------------------------------------------------------------------------
// comb1_core
// Registered 3-input lamp/alarm decision block. D, X and A are synchronized,
// combined into a 3-bit index {D,X,A} (D is the MSB) and looked up in the
// truth table TT. The result is registered onto L; a saturating counter
// tracks how many times L has gone from 0 to 1.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth per input (1..4); L lags an input change
//                by SYNC_STAGES+1 clk edges
//   TT           truth table, L_func = TT[{D,X,A}]
//   CNT_W        width of the activation counter
//
// Ports:
//   clk    rising-edge clock for all state
//   rst    synchronous active-high reset (clears syncs, L and l_cnt)
//   D/X/A  asynchronous level inputs (index bits 2/1/0)
//   clr    (COMB1_STICKY_EN only) clears the latched lamp; must be
//          synchronous to clk
//   L      registered lamp output
//   l_cnt  saturating count of L rising edges
//
// Build option:
//   COMB1_STICKY_EN  when defined, L latches 1 until clr is asserted; a
//                    simultaneous set (f=1) wins over clr.
// -----------------------------------------------------------------------------
module comb1_core
    import comb1_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter logic [7:0]  TT          = TT_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D,
    input  logic             X,
    input  logic             A,
`ifdef COMB1_STICKY_EN
    input  logic             clr,
`endif
    output logic             L,
    output logic [CNT_W-1:0] l_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [IDX_W-1:0] raw_idx_s;
    logic [IDX_W-1:0] sync_idx_s;
    logic             f_s;
    logic             l_next_s;
    logic             rise_s;
    logic [CNT_W-1:0] cnt_next_s;

    // l_r is the lamp register; its current value is also the "previous L"
    // used for edge detection, so no separate copy is kept.
    logic             l_r;
    logic [CNT_W-1:0] cnt_r;

    // Gather the raw inputs into table-index order.
    always_comb begin
        raw_idx_s = pack_idx(D, X, A);
    end

    // One shared chain keeps the three inputs aligned cycle-for-cycle.
    comb1_sync #(
        .N (SYNC_STAGES),
        .W (IDX_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_idx_s),
        .q   (sync_idx_s)
    );

    // Truth-table lookup on the synchronized index.
    always_comb begin
        f_s = tt_lookup(TT, sync_idx_s);
    end

    // Next lamp value: follow f, or latch until cleared in the sticky build.
    always_comb begin
        l_next_s = 1'b0;
`ifdef COMB1_STICKY_EN
        // Set has priority: f=1 keeps or raises L even while clr is high.
        l_next_s = f_s | (l_r & ~clr);
`else
        l_next_s = f_s;
`endif
    end

    // Count a 0->1 lamp transition, holding at the maximum instead of wrapping.
    always_comb begin
        rise_s     = l_next_s & ~l_r;
        cnt_next_s = cnt_r;
        if (rise_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Lamp and counter registers, updated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_r   <= 1'b0;
            cnt_r <= '0;
        end else begin
            l_r   <= l_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    assign L     = l_r;
    assign l_cnt = cnt_r;

endmodule

// File: tb/tb_comb1_core.sv
// -----------------------------------------------------------------------------
// tb_comb1_core
// Scoreboard bench for comb1_core. Each stimulus step applies one cycle of
// inputs, advances a reference model (a history of applied codes plus the
// lamp/counter rules) and queues the expected L/l_cnt. A monitor pops and
// compares after every rising edge. A few directed checks use constants
// taken straight from the lamp truth table.
// -----------------------------------------------------------------------------
module tb_comb1_core;

    localparam int         SYNC    = 2;
    localparam int         CNT_W   = 8;
    localparam logic [7:0] TT      = 8'hEA;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit l;
        int cnt;
        int step_no;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             D   = 1'b0;
    logic             X   = 1'b0;
    logic             A   = 1'b0;
    logic             clr = 1'b0;
    logic             L;
    logic [CNT_W-1:0] l_cnt;

    int   total   = 0;
    int   bad     = 0;
    int   n_steps = 0;
    exp_t sbq[$];
    exp_t mon_e;

    // reference model state
    int   hist[$];
    bit   m_l   = 1'b0;
    int   m_cnt = 0;
    logic [7:0] tt_v = TT;

    always #5 clk = ~clk;

    comb1_core #(
        .SYNC_STAGES (SYNC),
        .TT          (TT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .D     (D),
        .X     (X),
        .A     (A),
`ifdef COMB1_STICKY_EN
        .clr   (clr),
`endif
        .L     (L),
        .l_cnt (l_cnt)
    );

    // One clock cycle of stimulus; model predicts the state after the next edge.
    task automatic step(input bit r, input bit d, input bit x, input bit a, input bit c);
        bit   f;
        bit   nl;
        exp_t e;
        @(negedge clk);
        rst = r; D = d; X = x; A = a; clr = c;
        if (r) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(0);
            m_l   = 1'b0;
            m_cnt = 0;
        end else begin
            hist.push_back(int'({d, x, a}));
            f = tt_v[hist.pop_front()];
`ifdef COMB1_STICKY_EN
            nl = f | (m_l & ~c);
`else
            nl = f;
`endif
            if (nl && !m_l && m_cnt < CNT_MAX) m_cnt++;
            m_l = nl;
        end
        e.l = m_l; e.cnt = m_cnt; e.step_no = n_steps;
        n_steps++;
        sbq.push_back(e);
    endtask

    task automatic hold(input int n, input bit d, input bit x, input bit a, input bit c);
        for (int i = 0; i < n; i++) step(1'b0, d, x, a, c);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Wait until the edge of the last queued step has settled.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one comparison per edge that has a queued expectation.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            total++;
            if (L !== mon_e.l || l_cnt !== CNT_W'(mon_e.cnt)) begin
                bad++;
                $display("FAIL scoreboard step %0d: got L=%0b l_cnt=%0d, expected L=%0b l_cnt=%0d",
                         mon_e.step_no, L, l_cnt, mon_e.l, mon_e.cnt);
            end
        end
    end

    initial begin
        int code;
        int len;
        bit c;

        // reset, idle
        do_reset();
        hold(3, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_val("reset_idle_L", int'(L), 0);
        check_val("reset_idle_cnt", int'(l_cnt), 0);

        // A rises: L must appear exactly on the third edge
        hold(2, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("latency_early_L", int'(L), 0);
        hold(1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("latency_exact_L", int'(L), 1);
        check_val("latency_exact_cnt", int'(l_cnt), 1);

        // table sequence 001,011,111,101,100
        do_reset();
        hold(3, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(10, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(10, 1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("seq_101_L", int'(L), 1);
        hold(10, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
`ifdef COMB1_STICKY_EN
        check_val("seq_100_L", int'(L), 1);
`else
        check_val("seq_100_L", int'(L), 0);
`endif
        check_val("seq_cnt", int'(l_cnt), 1);

        // exhaustive walk of all codes (lamp on only for 1,3,5,6,7)
        do_reset();
        for (int k = 0; k < 8; k++) begin
            hold(5, k[2], k[1], k[0], 1'b1);
            settle();
            check_val($sformatf("walk_code%0d_L", k), int'(L),
                      (k == 1 || k == 3 || k == 5 || k == 6 || k == 7) ? 1 : 0);
        end

        // randomized codes, hold lengths, clears and occasional resets
        for (int n = 0; n < 250; n++) begin
            code = int'($urandom_range(7, 0));
            len  = int'($urandom_range(4, 1));
            c    = ($urandom_range(3, 0) == 0);
            if ($urandom_range(49, 0) == 0) begin
                step(1'b1, code[2], code[1], code[0], c);
            end else begin
                hold(len, code[2], code[1], code[0], c);
            end
        end

        // saturation: 300 pulses on A
        do_reset();
        for (int p = 0; p < 300; p++) begin
            hold(3, 1'b0, 1'b0, 1'b1, 1'b0);
            hold(3, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        settle();
        check_val("sat_cnt", int'(l_cnt), 255);
        hold(3, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("sat_hold_cnt", int'(l_cnt), 255);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("midrun_rst_L", int'(L), 0);
        check_val("midrun_rst_cnt", int'(l_cnt), 0);

`ifdef COMB1_STICKY_EN
        // sticky lamp and clear
        do_reset();
        hold(5, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(5, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_val("sticky_hold_L", int'(L), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check_val("sticky_clr_L", int'(L), 0);
        hold(5, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check_val("sticky_setwins_L", int'(L), 1);
        check_val("sticky_cnt", int'(l_cnt), 2);
`endif

        // let the monitor drain the scoreboard, bounded
        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
        #3;
        check_val("scoreboard_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comb1_core.md
Name: comb1_core

Overview:
- Registered 3-input lamp/alarm decision block.
- Inputs D, X and A are asynchronous level signals, e.g. door, key and alarm-arm switches.
- Each input is synchronized, then a truth-table function produces lamp output L.
- A saturating counter counts L activations for status readout.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input (legal range 1..4).
- TT, 8'hEA, truth table. L_func = TT[{D,X,A}], with D as the MSB of the index. The default gives L = (D & X) | A.
- CNT_W, 8, width of the activation counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- D  input  1  asynchronous level input (index bit 2).
- X  input  1  asynchronous level input (index bit 1).
- A  input  1  asynchronous level input (index bit 0).
- L  output  1  registered lamp output.
- l_cnt  output  CNT_W  saturating count of L rising edges.

Behaviour:
- Reset: when rst=1 at a rising clk edge:
  - all synchronizer flops clear to 0;
  - L clears to 0;
  - l_cnt clears to 0;
  - the internal L-previous flop clears to 0.
- Reset overrides every other update in the same cycle.
- Reset mid-operation discards in-flight synchronizer contents.
- Synchronization: each of D, X and A passes through SYNC_STAGES flops, giving ds, xs and as_.
- Function: f = TT[{ds,xs,as_}], evaluated combinationally; L <= f each cycle.
- Latency: an input level change is reflected on L exactly SYNC_STAGES+1 clk edges later, provided the input meets setup and hold.
- Default function, index {D,X,A} -> L:
  - 000 -> 0, 001 -> 1, 010 -> 0, 011 -> 1;
  - 100 -> 0, 101 -> 1, 110 -> 1, 111 -> 1.
- Counter: on any cycle where the new L=1 and the previous L=0, l_cnt increments by 1.
- l_cnt saturates at 2^CNT_W-1 and never wraps. It updates in the same edge as L.
- Simultaneous input changes: treated as one new index once synchronized, with no intermediate state required. Skew between inputs near a clock edge may produce a one-cycle intermediate code; this is accepted.
- Output holds its value while the inputs are stable. No combinational path from inputs to outputs.

Optional Feature:
- Macro: COMB1_STICKY_EN.
- With the macro defined:
  - an extra input port clr (1 bit) is added after A;
  - L_next = f | (L & ~clr), so L latches 1 until cleared;
  - if clr and f=1 occur in the same cycle, L stays/becomes 1 (set wins);
  - l_cnt counts only L 0->1 transitions;
  - rst still clears L.
- Without the macro: no clr port, and L follows f registered, as above.

Decomposition:
- Package comb1_pkg:
  - constant TT_DEFAULT = 8'hEA;
  - index bit-position constants IDX_D=2, IDX_X=1, IDX_A=0;
  - default SYNC_STAGES and CNT_W constants.
- Sub-module comb1_sync: parameterized N-stage, W-bit synchronizer with clk and synchronous rst. Instantiated once with W=3.

Test Plan:
- Reset, then D=X=A=0 held -> L=0 and l_cnt=0 after 3 cycles.
- From 000, set A=1 -> L=1 exactly SYNC_STAGES+1=3 edges later; l_cnt=1.
- Sequence from the default table, each step held 10 cycles:
  - A=1 -> L=1;
  - X=1 -> L=1;
  - D=1 -> L=1;
  - X=0 (101) -> L=1;
  - A=0 (100) -> L=0;
  - final l_cnt=1.
- Exhaustive walk of all 8 codes {D,X,A}, each held 5 cycles -> L matches TT bit; with TT=8'hEA, L=1 only for codes 1,3,5,6,7.
- Toggle A 0/1 for 300 pulses with CNT_W=8 -> l_cnt saturates at 255. Assert rst mid-run -> L=0 and l_cnt=0 the next edge.
- With COMB1_STICKY_EN:
  - A=1 then A=0 -> L stays 1;
  - pulse clr with f=0 -> L=0 the next edge;
  - clr with A=1 -> L remains 1.
